// File: rtl/simon_gen_pkg.sv
// Shared types and LED encodings for the Simon game core.
package simon_gen_pkg;

  typedef enum logic [2:0] {
    MODE_INPUT    = 3'd0,
    MODE_PLAYBACK = 3'd1,
    MODE_REPEAT   = 3'd2,
    MODE_DONE     = 3'd3,
    MODE_WIN      = 3'd4
  } mode_e;

  localparam logic [2:0] MODE_LED_INPUT    = 3'b001;
  localparam logic [2:0] MODE_LED_PLAYBACK = 3'b010;
  localparam logic [2:0] MODE_LED_REPEAT   = 3'b100;
  localparam logic [2:0] MODE_LED_DONE     = 3'b111;
  localparam logic [2:0] MODE_LED_WIN      = 3'b011;

endpackage

// File: rtl/simon_gen_if.sv
// Player-facing bus: switches in, LED/score displays out.
interface simon_gen_if #(
  parameter int unsigned PAT_W = 4,
  parameter int unsigned DEPTH = 64
);
  localparam int unsigned ADDR_W = $clog2(DEPTH);

  logic [PAT_W-1:0]  pattern;
  logic [PAT_W-1:0]  pattern_leds;
  logic [2:0]        mode_leds;
  logic [ADDR_W:0]   score;

  // master drives the switches; slave is the game core
  modport master (output pattern, input pattern_leds, input mode_leds, input score);
  modport slave  (input pattern, output pattern_leds, output mode_leds, output score);
endinterface

// File: rtl/simon_gen_mem.sv
// Sequence storage: synchronous write, asynchronous read, no reset.
module simon_gen_mem #(
  parameter int unsigned PAT_W  = 4,
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [PAT_W-1:0]  wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [PAT_W-1:0]  rdata_o
);

  logic [PAT_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/simon_gen.sv
// Simon game core: record, play back and verify a growing pattern sequence.
module simon_gen
  import simon_gen_pkg::*;
#(
  parameter int unsigned PAT_W  = 4,
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic         pclk,
  input  logic         rst_n,
  input  logic         level,
  simon_gen_if.slave   bus
);

  localparam int unsigned LEN_W = ADDR_W + 1;

  mode_e             mode_q, mode_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              lvl_q;

  logic              mem_we;
  logic [PAT_W-1:0]  mem_rdata;
  logic [LEN_W-1:0]  len_m1;
  logic              idx_last;
  logic              seq_full;
  logic              one_hot;
  logic              pat_valid;
  logic              pat_match;

  simon_gen_mem #(
    .PAT_W  (PAT_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (pclk),
    .we_i    (mem_we),
    .waddr_i (len_q[ADDR_W-1:0]),
    .wdata_i (bus.pattern),
    .raddr_i (idx_q),
    .rdata_o (mem_rdata)
  );

  // idx wraps at the stored length, not at the memory depth
  assign len_m1    = len_q - LEN_W'(1);
  assign idx_last  = ({1'b0, idx_q} == len_m1);
  assign seq_full  = (len_q == LEN_W'(DEPTH));
  assign one_hot   = (bus.pattern != '0) &&
                     ((bus.pattern & (bus.pattern - PAT_W'(1))) == '0);
  assign pat_valid = lvl_q | one_hot;
  assign pat_match = (bus.pattern == mem_rdata);

  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      mode_q <= MODE_INPUT;
      len_q  <= '0;
      idx_q  <= '0;
      lvl_q  <= level;
    end else begin
      mode_q <= mode_d;
      len_q  <= len_d;
      idx_q  <= idx_d;
    end
  end

  always_comb begin
    mode_d = mode_q;
    len_d  = len_q;
    idx_d  = idx_q;
    mem_we = 1'b0;
    unique case (mode_q)
      MODE_INPUT: begin
        if (pat_valid && !seq_full) begin
          mem_we = 1'b1;
          len_d  = len_q + LEN_W'(1);
          idx_d  = '0;
          mode_d = MODE_PLAYBACK;
        end
      end
      MODE_PLAYBACK: begin
        if (idx_last) begin
          idx_d  = '0;
          mode_d = MODE_REPEAT;
        end else begin
          idx_d  = idx_q + ADDR_W'(1);
        end
      end
      MODE_REPEAT: begin
        if (!pat_match) begin
          idx_d  = '0;
          mode_d = MODE_DONE;
        end else if (!idx_last) begin
          idx_d  = idx_q + ADDR_W'(1);
        end else begin
          idx_d  = '0;
          mode_d = seq_full ? MODE_WIN : MODE_INPUT;
        end
      end
      MODE_DONE, MODE_WIN: begin
        idx_d = idx_last ? '0 : idx_q + ADDR_W'(1);
      end
      default: begin
        mode_d = MODE_INPUT;
        idx_d  = '0;
      end
    endcase
  end

  // displays follow the registered mode; INPUT/REPEAT echo the switches
  always_comb begin
    bus.mode_leds    = MODE_LED_INPUT;
    bus.pattern_leds = bus.pattern;
    unique case (mode_q)
      MODE_INPUT:    bus.mode_leds = MODE_LED_INPUT;
      MODE_PLAYBACK: begin
        bus.mode_leds    = MODE_LED_PLAYBACK;
        bus.pattern_leds = mem_rdata;
      end
      MODE_REPEAT:   bus.mode_leds = MODE_LED_REPEAT;
      MODE_DONE: begin
        bus.mode_leds    = MODE_LED_DONE;
        bus.pattern_leds = mem_rdata;
      end
      MODE_WIN: begin
        bus.mode_leds    = MODE_LED_WIN;
        bus.pattern_leds = mem_rdata;
      end
      default:       bus.mode_leds = MODE_LED_INPUT;
    endcase
  end

  assign bus.score = len_q;

endmodule
